// File: rtl/and_unit_arbiter_pkg.sv
// rtl/and_unit_arbiter_pkg.sv - shared state and port-id encodings for the AND-unit arbiter
package and_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/and_array.sv
// rtl/and_array.sv - combinational WIDTH-bit bitwise AND datapath
module and_array #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin chooser; on contention the port not granted last wins
module rr_pick2
  import and_unit_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = valid0 | valid1;
  assign gnt_id    = (valid0 & valid1) ? ~last_grant : (valid1 ? PORT1 : PORT0);

endmodule

// File: rtl/and_unit_arbiter.sv
// rtl/and_unit_arbiter.sv - round-robin arbiter sharing one AND datapath between two requesters
module and_unit_arbiter
  import and_unit_arbiter_pkg::*;
#(
  parameter int   WIDTH   = 16,
  parameter logic RR_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, and_out;
  logic             op_id, last_grant;
  logic             gnt_valid, gnt_id, grant_fire;

  rr_pick2 u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  and_array #(.WIDTH(WIDTH)) u_and (
    .a (op_a),
    .b (op_b),
    .y (and_out)
  );

  // Gated by rst so readies stay low while reset is held.
  assign grant_fire = (state == IDLE) & gnt_valid & ~rst;
  assign req0_ready = grant_fire & (gnt_id == PORT0);
  assign req1_ready = grant_fire & (gnt_id == PORT1);
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_fire) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= PORT0;
      last_grant <= RR_INIT;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= PORT0;
    end else begin
      state <= state_next;
      if (grant_fire) begin
        op_a       <= gnt_id ? req1_a : req0_a;
        op_b       <= gnt_id ? req1_b : req0_b;
        op_id      <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_data  <= and_out;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      // rsp_data is left untouched on completion; only valid drops.
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_and_unit_arbiter.sv
// tb/tb_and_unit_arbiter.sv - directed self-checking bench for and_unit_arbiter
module tb_and_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and_unit_arbiter #(.WIDTH(16), .RR_INIT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp_valid, busy, rsp_id} !== 3'b000 || rsp_data !== 16'h0000) begin
      errors++; $display("FAIL reset_state got v=%b busy=%b id=%b data=%h exp 0 0 0 0000",
                         rsp_valid, busy, rsp_id, rsp_data);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'h3C3C;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_exec got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h3030 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL single_rsp got v=%b data=%h id=%b exp 1 3030 0", rsp_valid, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    logic exp;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'hFF00; req0_b = 16'h0FF0;
    req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req0_ready !== ~exp || req1_ready !== exp) begin
        errors++; $display("FAIL fair_grant%0d got busy=%b r0=%b r1=%b exp busy=0 grant=%b",
                           i, busy, req0_ready, req1_ready, exp);
      end
      step();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL fair_exec%0d got busy=%b v=%b exp 1 0", i, busy, rsp_valid);
      end
      step();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp || rsp_data !== (exp ? 16'h000F : 16'h0F00)) begin
        errors++; $display("FAIL fair_rsp%0d got v=%b id=%b data=%h exp 1 %b %h",
                           i, rsp_valid, rsp_id, rsp_data, exp, exp ? 16'h000F : 16'h0F00);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic test_hold();
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h1234;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_ready got %b exp 01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h1111;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_id !== 1'b1 ||
          {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_cyc%0d got v=%b data=%h id=%b rdy=%b exp 1 1234 1 00",
                           i, rsp_valid, rsp_data, rsp_id, {req0_ready, req1_ready});
      end
      step();
    end
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_done got v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [15:0] ve [2];
    va[0] = 16'h0000; vb[0] = 16'hFFFF; ve[0] = 16'h0000;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; ve[1] = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i];
      @(negedge clk);
      step();
      req0_valid = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ve[i] || rsp_id !== 1'b0) begin
        errors++; $display("FAIL boundary%0d got v=%b data=%h id=%b exp 1 %h 0",
                           i, rsp_valid, rsp_data, rsp_id, ve[i]);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_in_resp();
    req0_valid = 1'b1; req0_a = 16'hAAAA; req0_b = 16'hFFFF;
    step();
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hAAAA) begin
      errors++; $display("FAIL rstresp_pre got v=%b data=%h exp 1 aaaa", rsp_valid, rsp_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'h0000) begin
      errors++; $display("FAIL rstresp_async got v=%b busy=%b data=%h exp 0 0 0000", rsp_valid, busy, rsp_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h00F0;
    req1_valid = 1'b1; req1_a = 16'h0F00;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rstresp_first_grant got %b exp 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_drop();
    req1_valid = 1'b1; req1_a = 16'h5555; req1_b = 16'h0FF0;
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00 || rsp_data !== 16'h0550) begin
      errors++; $display("FAIL drop_resp got rdy=%b data=%h exp 00 0550", {req0_ready, req1_ready}, rsp_data);
    end
    step();
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL drop_idle%0d got v=%b busy=%b exp 0 0", i, rsp_valid, busy);
      end
      step();
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_boundary();
    test_reset_in_resp();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
